uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between up to N_REQ byte producers: the scan controller's distance/angle reports, status, and debug streams. Requesters present a byte with a level request. The arbiter picks one round-robin and drives the transmitter's active-low write strobe. It then waits for the transmitter to take the byte. A per-requester lock keeps ownership across multi-byte packets, and a watchdog recovers from a transmitter that never responds.

---
 rtl/uart_tx_arbiter_if.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundle of signals between the byte producers/UART transmitter and the
// transmitter arbiter.
//
// Signals:
//   req         per-requester byte-valid level
//   lock        per-requester keep-ownership flag, sampled together with req
//   req_data    byte of requester i at bits [8i+7:8i]
//   gnt         one-hot, one-cycle pulse: byte of requester i accepted
//   tx_rdy      transmitter idle/ready
//   data_wen    active-low write strobe to the transmitter
//   data        byte to the transmitter (registered)
//   busy        arbiter not idle, or an owner is held
//   err_timeout one-cycle pulse when the watchdog expires
//
// Modports:
//   master  the producer/transmitter side (drives req, lock, req_data, tx_rdy)
//   slave   the arbiter side
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 3
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   lock;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   gnt;
   logic               tx_rdy;
   logic               data_wen;
   logic [7:0]         data;
   logic               busy;
   logic               err_timeout;

   modport master (
      output req, lock, req_data, tx_rdy,
      input  gnt, data_wen, data, busy, err_timeout
   );

   modport slave (
      input  req, lock, req_data, tx_rdy,
      output gnt, data_wen, data, busy, err_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ byte producers. A round-robin
// pick is made among the requesters, the chosen byte is written with a
// single-cycle active-low strobe, and the arbiter then waits for the
// transmitter to drop tx_rdy (meaning it took the byte). A requester may
// hold ownership across a multi-byte packet with its lock flag, and a
// watchdog abandons the wait if the transmitter never responds.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_arbiter_if.slave (req, lock, req_data, tx_rdy in;
//          gnt, data_wen, data, busy, err_timeout out)
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  cycles to wait for tx_rdy to fall after a strobe (>=1)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 1023
) (
   input logic               clk,
   input logic               rst_n,
   uart_tx_arbiter_if.slave  bus
);

   localparam int IDXW = $clog2(N_REQ);
   localparam int CW   = $clog2(TIMEOUT + 1);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] STROBE    = 2'd1;
   localparam logic [1:0] WAIT_TAKE = 2'd2;

   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   logic [1:0]       r_state;
   logic [IDXW-1:0]  r_rr;
   logic             r_ownerValid;
   logic [IDXW-1:0]  r_owner;
   logic [CW-1:0]    r_cnt;
   logic [7:0]       r_data;
   logic             r_dataWen;
   logic [N_REQ-1:0] r_gnt;
   logic             r_errTimeout;

   logic             w_release;
   logic             w_ownerHeld;
   logic [N_REQ-1:0] w_eligible;
   logic             w_found;
   logic [IDXW-1:0]  w_winner;
   logic [IDXW-1:0]  w_cand;
   logic [7:0]       w_winData;

   // Eligibility and round-robin winner selection. A held owner whose lock
   // has just dropped is released on this same edge, so the arbitration
   // below already sees every requester as eligible. The search starts one
   // past the last winner and wraps, which gives the requester after the
   // previous winner top priority.
   always_comb begin
      w_release   = r_ownerValid && !bus.lock[r_owner];
      w_ownerHeld = r_ownerValid && !w_release;
      w_eligible  = w_ownerHeld ? (bus.req & (ONE << r_owner)) : bus.req;

      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_cand = IDXW'((int'(r_rr) + k) % N_REQ);
         if (!w_found && w_eligible[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end

      w_winData = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_winner == IDXW'(k)) begin
            w_winData = bus.req_data[8*k +: 8];
         end
      end
   end

   // Main state machine. IDLE accepts a byte when the transmitter is ready,
   // STROBE lasts exactly one cycle with data_wen low and gnt high, and
   // WAIT_TAKE waits for tx_rdy to fall. When the watchdog fires the byte is
   // treated as sent: no retry and the owner is left as it was.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_rr         <= IDXW'(N_REQ - 1);
         r_ownerValid <= 1'b0;
         r_owner      <= '0;
         r_cnt        <= '0;
         r_data       <= 8'h00;
         r_dataWen    <= 1'b1;
         r_gnt        <= '0;
         r_errTimeout <= 1'b0;
      end else begin
         r_errTimeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_release) begin
                  r_ownerValid <= 1'b0;
               end
               if (bus.tx_rdy && w_found) begin
                  r_data       <= w_winData;
                  r_dataWen    <= 1'b0;
                  r_gnt        <= ONE << w_winner;
                  r_rr         <= w_winner;
                  r_owner      <= w_winner;
                  r_ownerValid <= bus.lock[w_winner];
                  r_state      <= STROBE;
               end
            end
            STROBE: begin
               r_dataWen <= 1'b1;
               r_gnt     <= '0;
               r_cnt     <= '0;
               r_state   <= WAIT_TAKE;
            end
            WAIT_TAKE: begin
               if (!bus.tx_rdy) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CW'(TIMEOUT - 1)) begin
                     r_errTimeout <= 1'b1;
                     r_state      <= IDLE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt         = r_gnt;
   assign bus.data_wen    = r_dataWen;
   assign bus.data        = r_data;
   assign bus.err_timeout = r_errTimeout;
   assign bus.busy        = (r_state != IDLE) || r_ownerValid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. Each requester is fed from a byte
// queue; a transaction-level reference model replays the arbitration rules
// on those queues to predict the order of grants, and a monitor compares
// every strobe against the predicted order. A small transmitter model
// acknowledges strobes, refuses to (for the watchdog), or is driven by hand.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N  = 3;
   localparam int TO = 8;

   localparam int TX_ACK    = 0;
   localparam int TX_NOACK  = 1;
   localparam int TX_MANUAL = 2;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } byteT;

   typedef struct packed {
      int         idx;
      logic [7:0] d;
   } expT;

   logic clk = 1'b0;
   logic rst_n;

   uart_tx_arbiter_if #(.N_REQ(N)) bus ();

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   byteT reqQ [N][$];
   expT  sbQ [$];

   int nChecks = 0;
   int nFails  = 0;
   int strobeCount = 0;
   int timeouts = 0;
   int tick = 0;
   int strobeTick = 0;
   bit armed = 1'b0;
   bit prevWenLow = 1'b0;

   int mRr = N - 1;
   bit mOwnValid = 1'b0;
   int mOwner = 0;

   int txMode = TX_MANUAL;
   bit txManual = 1'b1;
   bit txPend = 1'b0;
   int txDelay = 0;
   int txBusy = 0;

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic addByte(input int i, input logic [7:0] d, input logic l);
      byteT b;
      b.d = d;
      b.l = l;
      reqQ[i].push_back(b);
   endtask

   // Replays the arbitration rules on a copy of the requester queues. Since
   // requesters present their next byte in the grant cycle, every decision
   // sees exactly the requesters whose queues are non-empty, and the lock
   // flag of an owner is the flag of its head byte (0 once it is empty).
   task automatic applyStimulus();
      byteT q [N][$];
      int total;
      int w;
      expT e;
      total = 0;
      for (int i = 0; i < N; i++) begin
         q[i] = reqQ[i];
         total += q[i].size();
      end
      repeat (total) begin
         if (mOwnValid && !(q[mOwner].size() > 0 && q[mOwner][0].l)) mOwnValid = 1'b0;
         if (mOwnValid) begin
            w = mOwner;
         end else begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (mRr + k) % N;
               if (w < 0 && q[c].size() > 0) w = c;
            end
         end
         e.idx = w;
         e.d   = q[w][0].d;
         sbQ.push_back(e);
         mOwnValid = q[w][0].l;
         mOwner    = w;
         mRr       = w;
         void'(q[w].pop_front());
      end
      if (mOwnValid && q[mOwner].size() == 0) mOwnValid = 1'b0;
   endtask

   task automatic waitDrain();
      int budget;
      budget = 3000;
      while (sbQ.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checkOutput("drain", sbQ.size(), 0);
      repeat (12) @(negedge clk);
      checkOutput("busy_idle", bus.busy, 0);
   endtask

   // Requesters: drop the granted byte and present the next one in the
   // grant cycle, so the arbiter sees the new byte on its next decision.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (bus.gnt[i] === 1'b1 && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
         if (reqQ[i].size() > 0) begin
            bus.req[i]            = 1'b1;
            bus.lock[i]           = reqQ[i][0].l;
            bus.req_data[8*i +: 8] = reqQ[i][0].d;
         end else begin
            bus.req[i]            = 1'b0;
            bus.lock[i]           = 1'b0;
            bus.req_data[8*i +: 8] = 8'h00;
         end
      end
   end

   // Transmitter: in ACK mode it takes each strobed byte after a random
   // delay and stays busy a few cycles; NOACK never responds; MANUAL
   // follows txManual.
   always @(negedge clk) begin
      if (txMode == TX_MANUAL) begin
         bus.tx_rdy = txManual;
         txPend     = 1'b0;
      end else if (txPend) begin
         if (txDelay > 0) begin
            txDelay--;
         end else if (txBusy > 0) begin
            bus.tx_rdy = 1'b0;
            txBusy--;
         end else begin
            bus.tx_rdy = 1'b1;
            txPend     = 1'b0;
         end
      end else if (bus.data_wen === 1'b0 && txMode == TX_ACK) begin
         txPend  = 1'b1;
         txDelay = $urandom_range(0, 2);
         txBusy  = $urandom_range(1, 3);
      end else begin
         bus.tx_rdy = 1'b1;
      end
   end

   // Monitor: every strobe is compared with the next predicted grant, and
   // every watchdog pulse must follow an unacknowledged strobe by TO+1 cycles.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.data_wen === 1'b0) begin
            expT e;
            strobeCount++;
            checkOutput("wen_pulse_width", prevWenLow, 0);
            checkOutput("strobe_expected", sbQ.size() != 0, 1);
            if (sbQ.size() != 0) begin
               e = sbQ.pop_front();
               checkOutput("gnt", bus.gnt, 32'(1) << e.idx);
               checkOutput("data", bus.data, e.d);
            end
            if (txMode == TX_NOACK) begin
               armed      = 1'b1;
               strobeTick = tick;
            end
         end else if (bus.gnt !== '0) begin
            checkOutput("gnt_without_strobe", bus.gnt, 0);
         end
         if (bus.err_timeout === 1'b1) begin
            timeouts++;
            checkOutput("timeout_expected", armed, 1);
            if (armed) checkOutput("timeout_latency", tick - strobeTick, TO + 1);
            armed = 1'b0;
         end
         prevWenLow = (bus.data_wen === 1'b0);
      end else begin
         prevWenLow = 1'b0;
      end
      tick++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      int saved;
      int budget;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_wen", bus.data_wen, 1);
      checkOutput("reset_data", bus.data, 0);
      checkOutput("reset_gnt", bus.gnt, 0);
      checkOutput("reset_busy", bus.busy, 0);
      checkOutput("reset_err", bus.err_timeout, 0);
      rst_n = 1'b1;
      @(negedge clk);
      txMode = TX_ACK;

      $display("[TB] single requester");
      addByte(0, 8'h5A, 1'b0);
      applyStimulus();
      waitDrain();

      $display("[TB] fairness");
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < N; i++) addByte(i, 8'(16 * i + k + 1), 1'b0);
      end
      applyStimulus();
      waitDrain();

      $display("[TB] lock");
      addByte(1, 8'hA1, 1'b1);
      addByte(1, 8'hA2, 1'b1);
      addByte(1, 8'hA3, 1'b1);
      addByte(0, 8'hB0, 1'b0);
      addByte(2, 8'hB2, 1'b0);
      applyStimulus();
      waitDrain();

      $display("[TB] back-pressure");
      txMode = TX_MANUAL;
      txManual = 1'b0;
      repeat (2) @(negedge clk);
      addByte(1, 8'hC3, 1'b0);
      applyStimulus();
      saved = strobeCount;
      repeat (5) @(negedge clk);
      #1;
      checkOutput("bp_no_strobe", strobeCount, saved);
      txManual = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("bp_not_yet", bus.data_wen, 1);
      @(negedge clk);
      #1;
      checkOutput("bp_strobe", bus.data_wen, 0);
      txManual = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      txManual = 1'b1;
      @(negedge clk);
      txMode = TX_ACK;
      waitDrain();

      $display("[TB] watchdog");
      txMode = TX_NOACK;
      saved = timeouts;
      addByte(0, 8'h3C, 1'b0);
      applyStimulus();
      waitDrain();
      checkOutput("wd_pulse", timeouts, saved + 1);
      txMode = TX_ACK;
      addByte(2, 8'h7E, 1'b0);
      addByte(1, 8'h81, 1'b0);
      applyStimulus();
      waitDrain();

      $display("[TB] random");
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < N; i++) begin
            int n;
            n = $urandom_range(0, 4);
            for (int b = 0; b < n; b++) addByte(i, 8'($urandom), ($urandom_range(0, 2) == 0));
         end
         applyStimulus();
         waitDrain();
      end

      $display("[TB] reset during wait");
      txMode = TX_NOACK;
      addByte(2, 8'hE7, 1'b1);
      applyStimulus();
      saved = strobeCount;
      budget = 200;
      while (strobeCount == saved && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checkOutput("rst_test_strobe", strobeCount != saved, 1);
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_wen", bus.data_wen, 1);
      checkOutput("rst_gnt", bus.gnt, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_data", bus.data, 0);
      checkOutput("rst_sb_empty", sbQ.size(), 0);
      sbQ.delete();
      for (int i = 0; i < N; i++) reqQ[i].delete();
      armed = 1'b0;
      mRr = N - 1;
      mOwnValid = 1'b0;
      mOwner = 0;
      txMode = TX_ACK;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      addByte(0, 8'h10, 1'b0);
      addByte(1, 8'h11, 1'b0);
      addByte(2, 8'h12, 1'b0);
      applyStimulus();
      waitDrain();

      checkOutput("timeout_total", timeouts, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
